// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter: FSM state codes and response codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  // Encodings are visible on arb_state, so they are fixed rather than tool-chosen.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request searching upward from ptr+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
//   req     in  N   request levels
//   ptr     in  PW  index of the last requester served
//   grant   out N   one-hot grant (all zero when no request)
//   any_req out 1   at least one request is set
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any_req
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // Offsets 1..N visit every requester once, ending on ptr itself.
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C byte master among NUM_REQ requesters, round-robin, one transaction per grant.
// Latency: req -> m_start 2 cycles (IDLE, ISSUE); m_done -> done 1 cycle; 1 idle cycle between grants.
// Backpressure: holds in ISSUE while m_busy; WAIT aborts after TIMEOUT_CYC cycles without m_done.
//   clk, rst (async, active-low)
//   req/req_rw/req_addr/req_wdata   per-requester request level and packed operands
//   gnt/done/rsp_rdata/rsp_err      grant, completion pulse and response to the requester
//   m_start/m_rw/m_addr/m_wdata/m_abort, m_busy/m_done/m_nack/m_rdata   master handshake
//   arb_state                       current FSM state for debug
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic                      m_start,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_abort,
  input  logic                      m_busy,
  input  logic                      m_done,
  input  logic                      m_nack,
  input  logic [DATA_W-1:0]         m_rdata,
  output logic [2:0]                arb_state
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, sel_idx, cur_idx;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 any_req;
  logic [CW-1:0]        cnt;
  logic                 ld_grant, issue, cap_done, tmo, fin;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_grant[i]) sel_idx = PW'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_grant  = 1'b0;
    issue     = 1'b0;
    cap_done  = 1'b0;
    tmo       = 1'b0;
    fin       = 1'b0;
    m_abort   = 1'b0;
    done      = '0;
    case (state)
      ST_IDLE: if (any_req) begin
        ld_grant  = 1'b1;
        state_nxt = ST_ISSUE;
      end
      // m_done arriving here belongs to nobody and is dropped.
      ST_ISSUE: if (!m_busy) begin
        issue     = 1'b1;
        state_nxt = ST_WAIT;
      end
      // A completion in the last allowed cycle beats the timeout.
      ST_WAIT: if (m_done) begin
        cap_done  = 1'b1;
        state_nxt = ST_RESP;
      end else if (cnt == CNT_LAST) begin
        tmo       = 1'b1;
        m_abort   = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        done      = gnt;
        fin       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= PW'(NUM_REQ - 1);
      cur_idx   <= '0;
      gnt       <= '0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_start   <= 1'b0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else begin
      m_start <= issue;
      // Operands are latched once so later requester changes cannot disturb the master.
      if (ld_grant) begin
        gnt     <= arb_grant;
        cur_idx <= sel_idx;
        m_rw    <= req_rw[sel_idx];
        m_addr  <= req_addr[sel_idx*ADDR_W +: ADDR_W];
        m_wdata <= req_wdata[sel_idx*DATA_W +: DATA_W];
      end
      if (issue)
        cnt <= '0;
      else if (state == ST_WAIT && cnt != '1)
        cnt <= cnt + CW'(1);
      if (cap_done) begin
        rsp_rdata <= m_rw ? m_rdata : '0;
        rsp_err   <= m_nack ? ERR_NACK : ERR_OK;
      end else if (tmo) begin
        rsp_rdata <= '0;
        rsp_err   <= ERR_TMO;
      end
      if (fin) begin
        gnt <= '0;
        ptr <= cur_idx;
      end
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0, req_rw = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  gnt, done;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_err;
  logic        m_start, m_rw, m_abort;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [7:0]  m_rdata = 8'hEE;
  logic [2:0]  arb_state;

  int n_vec = 0;
  int n_err = 0;
  int mptr;

  logic       rw_a [4];
  logic [6:0] ad_a [4];
  logic [7:0] wd_a [4];

  typedef struct {
    logic [3:0] req;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         busy;
    int         dly;
    bit         tmo;
    bit         nack;
    logic [7:0] rd;
    bit         stray;
    logic [3:0] exp_gnt;
    logic [1:0] exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  i2c_master_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Reference rule: priority list is ptr+1, ptr+2, ... wrapping; first requester asking wins.
  function automatic int model_pick(input logic [3:0] rq, input int p);
    int order[$];
    for (int k = 1; k <= 4; k++) order.push_back((p + k) % 4);
    foreach (order[j]) if (rq[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic drive_reqs(input logic [3:0] rq);
    req = rq;
    for (int i = 0; i < 4; i++) begin
      req_rw[i]             = rw_a[i];
      req_addr[i*7 +: 7]    = ad_a[i];
      req_wdata[i*8 +: 8]   = wd_a[i];
    end
  endtask

  // Entered in an IDLE cycle; returns in the IDLE cycle after RESP.
  task automatic txn(input logic [3:0] rq, input logic [3:0] eg, input int busy, input int dly,
                     input bit tmo, input bit nack, input logic [7:0] rd, input bit stray,
                     input bit drop, input logic [1:0] ee, input logic [7:0] er);
    int gi;
    logic [6:0] ea;
    logic erw;
    logic [7:0] ew;
    gi  = idx_of(eg);
    ea  = ad_a[gi];
    erw = rw_a[gi];
    ew  = wd_a[gi];
    drive_reqs(rq);
    m_busy = (busy > 0);
    tick();
    chk("grant", 32'(gnt), 32'(eg));
    chk("issue_state", 32'(arb_state), 32'd1);
    chk("m_addr", 32'(m_addr), 32'(ea));
    chk("m_rw", 32'(m_rw), 32'(erw));
    chk("m_wdata", 32'(m_wdata), 32'(ew));
    for (int i = 0; i < busy; i++) begin
      m_done = stray;
      tick();
      m_done = 1'b0;
      chk("busy_hold", 32'(arb_state), 32'd1);
      chk("busy_no_start", 32'(m_start), 32'd0);
      chk("busy_addr", 32'(m_addr), 32'(ea));
    end
    m_busy = 1'b0;
    tick();
    chk("m_start", 32'(m_start), 32'd1);
    chk("wait_state", 32'(arb_state), 32'd2);
    if (drop) begin
      req = '0;
      req_rw = ~req_rw;
      req_addr = ~req_addr;
      req_wdata = ~req_wdata;
    end
    for (int k = 1; k <= (tmo ? 16 : dly); k++) begin
      if (k > 1) chk("start_pulse", 32'(m_start), 32'd0);
      chk("abort_timing", 32'(m_abort), 32'(tmo && k == 16));
      chk("wait_addr", 32'(m_addr), 32'(ea));
      chk("wait_gnt", 32'(gnt), 32'(eg));
      chk("wait_no_done", 32'(done), 32'd0);
      tick();
    end
    if (!tmo) begin
      m_done = 1'b1;
      m_nack = nack;
      m_rdata = rd;
      #1;
      chk("done_beats_tmo", 32'(m_abort), 32'd0);
      tick();
      m_done = 1'b0;
      m_nack = 1'b0;
      m_rdata = 8'hEE;
    end
    chk("done", 32'(done), 32'(eg));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(er));
    chk("resp_state", 32'(arb_state), 32'd3);
    tick();
    chk("done_once", 32'(done), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
    chk("idle_state", 32'(arb_state), 32'd0);
    chk("rsp_hold", 32'(rsp_err), 32'(ee));
    chk("rdata_hold", 32'(rsp_rdata), 32'(er));
  endtask

  // Drive a single request into WAIT, reset asynchronously in WAIT cycle 'at',
  // then confirm req0 wins first from {req0, req3}.
  task automatic reset_in_wait(input int at);
    for (int i = 0; i < 4; i++) begin
      rw_a[i] = 1'b1;
      ad_a[i] = 7'(7'h60 + i);
      wd_a[i] = 8'(i);
    end
    drive_reqs(4'b0100);
    m_busy = 1'b0;
    tick();
    tick();
    for (int k = 1; k < at; k++) tick();
    if (at == 1) chk("pre_rst_start", 32'(m_start), 32'd1);
    else         chk("pre_rst_abort", 32'(m_abort), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_abort", 32'(m_abort), 32'd0);
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_addr", 32'(m_addr), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    tick();
    rst = 1'b1;
    mptr = 3;
    txn(4'b1001, 4'b0001, 0, 2, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 2'b00, 8'h12);
    mptr = 0;
  endtask

  initial begin
    vec_t v;
    logic [3:0] rq;
    logic [7:0] rd, er;
    logic [1:0] ee;
    int g, dly, busy;
    bit tmo, nack, drop;

    tbl[0]  = '{4'b0010, 1'b0, 7'h50, 8'hA5, 0, 3,  1'b0, 1'b0, 8'h77, 1'b0, 4'b0010, 2'b00, 8'h00};
    tbl[1]  = '{4'b0100, 1'b1, 7'h2A, 8'h00, 0, 0,  1'b0, 1'b1, 8'h3C, 1'b0, 4'b0100, 2'b01, 8'h3C};
    tbl[2]  = '{4'b1000, 1'b1, 7'h11, 8'h00, 0, 0,  1'b1, 1'b0, 8'h99, 1'b0, 4'b1000, 2'b10, 8'h00};
    tbl[3]  = '{4'b1111, 1'b0, 7'h20, 8'h01, 0, 1,  1'b0, 1'b0, 8'h55, 1'b0, 4'b0001, 2'b00, 8'h00};
    tbl[4]  = '{4'b1111, 1'b1, 7'h21, 8'h02, 1, 2,  1'b0, 1'b0, 8'h81, 1'b0, 4'b0010, 2'b00, 8'h81};
    tbl[5]  = '{4'b1111, 1'b0, 7'h22, 8'h03, 0, 0,  1'b0, 1'b1, 8'h44, 1'b0, 4'b0100, 2'b01, 8'h00};
    tbl[6]  = '{4'b1111, 1'b1, 7'h23, 8'h04, 2, 4,  1'b0, 1'b0, 8'h9F, 1'b0, 4'b1000, 2'b00, 8'h9F};
    tbl[7]  = '{4'b1111, 1'b0, 7'h24, 8'h05, 0, 1,  1'b0, 1'b0, 8'h12, 1'b0, 4'b0001, 2'b00, 8'h00};
    tbl[8]  = '{4'b1111, 1'b1, 7'h25, 8'h06, 0, 15, 1'b0, 1'b0, 8'hC3, 1'b0, 4'b0010, 2'b00, 8'hC3};
    tbl[9]  = '{4'b0101, 1'b1, 7'h40, 8'h00, 0, 5,  1'b0, 1'b1, 8'h66, 1'b0, 4'b0100, 2'b01, 8'h66};
    tbl[10] = '{4'b0001, 1'b0, 7'h33, 8'h5A, 5, 2,  1'b0, 1'b0, 8'hBB, 1'b1, 4'b0001, 2'b00, 8'h00};

    #3;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_start", 32'(m_start), 32'd0);
    chk("reset_abort", 32'(m_abort), 32'd0);
    chk("reset_state", 32'(arb_state), 32'd0);
    chk("reset_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
    chk("reset_mops", 32'({m_rw, m_addr, m_wdata}), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    mptr = 3;

    foreach (tbl[i]) begin
      v = tbl[i];
      for (int j = 0; j < 4; j++) begin
        rw_a[j] = ~v.rw;
        ad_a[j] = 7'(7'h70 + j);
        wd_a[j] = 8'(8'hF0 + j);
      end
      rw_a[idx_of(v.exp_gnt)] = v.rw;
      ad_a[idx_of(v.exp_gnt)] = v.addr;
      wd_a[idx_of(v.exp_gnt)] = v.wdata;
      txn(v.req, v.exp_gnt, v.busy, v.dly, v.tmo, v.nack, v.rd, v.stray, 1'b0,
          v.exp_err, v.exp_rdata);
      mptr = idx_of(v.exp_gnt);
    end

    for (int r = 0; r < 150; r++) begin
      rq = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) begin
        rw_a[j] = 1'($urandom);
        ad_a[j] = 7'($urandom);
        wd_a[j] = 8'($urandom);
      end
      g    = model_pick(rq, mptr);
      tmo  = ($urandom_range(0, 7) == 0);
      nack = 1'($urandom);
      rd   = 8'($urandom);
      dly  = $urandom_range(0, 15);
      busy = $urandom_range(0, 3);
      drop = ($urandom_range(0, 3) == 0);
      ee   = tmo ? 2'b10 : (nack ? 2'b01 : 2'b00);
      er   = (tmo || !rw_a[g]) ? 8'h00 : rd;
      txn(rq, 4'(1 << g), busy, dly, tmo, nack, rd, 1'b0, drop, ee, er);
      mptr = g;
    end

    reset_in_wait(1);
    reset_in_wait(16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
